gemm_tile_scheduler: RTL and testbench
======================================

# gemm_tile_scheduler

Sequences the RowPar×ColPar output-stationary MAC array through a full GeMM of arbitrary M×K×N. It splits M and N into RowPar/ColPar tiles, walks K for each tile, and drives the read-index, data-valid, accumulator-first, C-write and done strobes. The strobes are aligned to the 1-cycle SRAM read latency and the 1-cycle MAC register. It sits between the host start/size registers and the array/address-generation logic.

## Interface
- SizeAddrWidth, 8: width of size inputs, counters and bases
- RowPar, 4: array rows (M tile height)
- ColPar, 16: array columns (N tile width)

- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  start pulse; sampled only in IDLE
- M_size_i / K_size_i / N_size_i  in  SizeAddrWidth each  matrix dimensions; latched on accepted start
- busy_o  out  1  high from the cycle after accepted start until done_o inclusive
- done_o  out  1  one-cycle completion pulse
- issue_o  out  1  read index below valid this cycle
- k_o  out  SizeAddrWidth  K index of current read
- row_base_o / col_base_o  out  SizeAddrWidth  m_tile*RowPar / n_tile*ColPar of current read
- row_valid_o  out  RowPar  bit i = (row_base_o+i < M)
- col_valid_o  out  ColPar  bit j = (col_base_o+j < N)
- in_valid_o  out  1  SRAM data valid at array inputs (issue_o delayed 1)
- first_o  out  1  with in_valid_o: beat is k=0 of a tile; MAC loads instead of accumulating
- c_we_o  out  1  write tile results to C
- c_row_base_o / c_col_base_o  out  SizeAddrWidth  tile origin for the C write
- c_row_valid_o / c_col_valid_o  out  RowPar / ColPar  write masks for the C write

All outputs reset to 0.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE, accepted start:
  - Latch sizes.
  - Mt = ceil(M/RowPar), Nt = ceil(N/ColPar), computed with shifts when the parameters are powers of two, else integer division; width SizeAddrWidth.
  - Clear counters.
  - If any size is 0 → DONE (no issue, no write); else → RUN.
- RUN: issue_o=1 every cycle. Loop order: k innermost, then n_tile, then m_tile outermost.
  - k wraps at K-1 and increments n_tile.
  - n_tile wraps at Nt-1 and increments m_tile.
  - On the last (m,n,k) → DRAIN.
- DRAIN: 2 cycles (counter), issue_o=0, pipeline empties → DONE.
- DONE: done_o=1 for one cycle → IDLE.
- Pipeline:
  - Stage 1 registers issue, k==0 and tile info as in_valid_o/first_o.
  - Stage 2 asserts c_we_o one cycle after the in_valid_o beat whose k=K-1, with the C tile info of that tile.
- Masks:
  - Lanes beyond M/N are masked in row_valid_o/col_valid_o and c_*_valid_o.
  - Bases are never masked.
  - base+i is compared at SizeAddrWidth+1 bits to avoid wrap.
- start_i outside IDLE is ignored; input size changes during RUN are ignored.
- Reset at any point: immediate return to IDLE with all outputs 0; no partial done_o.

## Timing
- Accepted start at edge 0; T = Mt·Nt·K.
- issue_o cycles 1..T.
- in_valid_o cycles 2..T+1.
- c_we_o at cycles t·K+2 for t=1..Mt·Nt.
- DRAIN at cycles T+1..T+2; done_o at cycle T+3; busy_o at cycles 1..T+3.
- K=1: first_o on every beat; c_we_o back-to-back.
- Zero size: done_o at cycle 1, busy_o at cycle 1 only.
- Back-to-back: start_i in the cycle after done_o (IDLE) is accepted.

## Structure
- gemm_pkg: sched_state_e enum, SRAM_RD_LAT=1 and MAC_LAT=1 localparams, ceil_div function.
- Sub-module gemm_nested_counter:
  - Three chained wrap counters (k, n_tile, m_tile).
  - Inputs: enable, clear, limits.
  - Outputs: counts, per-level wrap, last.
  - Instantiated once.
- Valid/first/we/tile-info delay stage: inside the top.

## Test plan
- M=4,K=3,N=16 (one tile):
  - issue cycles 1–3 with k=0,1,2; first_o at cycle 2.
  - c_we_o at cycle 5, masks all-ones; done_o at cycle 6.
- M=5,K=2,N=17 (Mt=Nt=2, T=8):
  - Tile order (0,0),(0,16),(4,0),(4,16); c_we_o at cycles 4,6,8,10; done_o at cycle 11.
  - Tile (4,16): c_row_valid=4'b0001, c_col_valid=16'h0001.
- K=1, M=8, N=32: first_o on every beat; c_we_o at cycles 3–6 continuous; done_o at cycle 7.
- K=0, M=4, N=16: no issue_o or c_we_o; done_o at cycle 1.
- start_i pulsed at cycles 2 and 5 of a run: ignored, timing identical to a single start; a start in the cycle after done_o launches a second run.
- rst_ni low at cycle 3 of the M=5,K=2,N=17 run: all outputs 0 immediately, no done_o, state IDLE; a new start afterwards runs normally.

Source files
------------

// File: rtl/gemm_tile_scheduler_pkg.sv
// Shared types and constants for the GeMM tile scheduler.
//   sched_state_e : scheduler FSM states
//   SRAM_RD_LAT   : read latency from index issue to data at the array inputs
//   MAC_LAT       : MAC register latency from last beat to result available
//   DRAIN_CYCLES  : cycles spent emptying the pipeline after the last issue
//   ceil_div()    : rounded-up division used to count tiles per dimension
package gemm_tile_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } sched_state_e;

    localparam int SRAM_RD_LAT  = 1;
    localparam int MAC_LAT      = 1;
    localparam int DRAIN_CYCLES = SRAM_RD_LAT + MAC_LAT;

    // Divisors are elaboration constants, so a power-of-two divisor collapses
    // to a fixed right shift and only other divisors cost a real divider.
    function automatic logic [31:0] ceil_div(input logic [31:0] num, input logic [31:0] den);
        logic [31:0] sum;
        sum = num + den - 32'd1;
        for (int s = 0; s < 32; s++) begin
            if (den == (32'd1 << s)) begin
                return sum >> s;
            end
        end
        return sum / den;
    endfunction

endpackage

// File: rtl/gemm_tile_scheduler_if.sv
// Host and array-side signal bundle for the GeMM tile scheduler.
//   Host side   : start, m_size, k_size, n_size (to scheduler); busy, done (from scheduler)
//   Read side   : issue, k, row_base, col_base, row_valid, col_valid
//   Array side  : in_valid, first
//   C write     : c_we, c_row_base, c_col_base, c_row_valid, c_col_valid
// master = host/bench view, slave = scheduler view.
interface gemm_tile_scheduler_if #(
    parameter int SizeAddrWidth = 8,
    parameter int RowPar        = 4,
    parameter int ColPar        = 16
);

    logic                     start;
    logic [SizeAddrWidth-1:0] m_size;
    logic [SizeAddrWidth-1:0] k_size;
    logic [SizeAddrWidth-1:0] n_size;
    logic                     busy;
    logic                     done;
    logic                     issue;
    logic [SizeAddrWidth-1:0] k;
    logic [SizeAddrWidth-1:0] row_base;
    logic [SizeAddrWidth-1:0] col_base;
    logic [RowPar-1:0]        row_valid;
    logic [ColPar-1:0]        col_valid;
    logic                     in_valid;
    logic                     first;
    logic                     c_we;
    logic [SizeAddrWidth-1:0] c_row_base;
    logic [SizeAddrWidth-1:0] c_col_base;
    logic [RowPar-1:0]        c_row_valid;
    logic [ColPar-1:0]        c_col_valid;

    modport master (
        output start, m_size, k_size, n_size,
        input  busy, done, issue, k, row_base, col_base, row_valid, col_valid,
               in_valid, first, c_we, c_row_base, c_col_base, c_row_valid, c_col_valid
    );

    modport slave (
        input  start, m_size, k_size, n_size,
        output busy, done, issue, k, row_base, col_base, row_valid, col_valid,
               in_valid, first, c_we, c_row_base, c_col_base, c_row_valid, c_col_valid
    );

endinterface

// File: rtl/gemm_tile_scheduler_counter.sv
// Three chained wrap counters walking k (innermost), n_tile, m_tile (outermost).
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   clear                    : synchronous return of all counts to 0 (wins over enable)
//   enable                   : advance one step this cycle
//   k_limit/n_limit/m_limit  : loop trip counts; each count wraps at limit-1
//   k_cnt/n_cnt/m_cnt        : current loop indices
//   k_wrap                   : k is at its last value (end of a tile's K walk)
//   last                     : all three levels at their last value
module gemm_nested_counter #(
    parameter int Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear,
    input  logic             enable,
    input  logic [Width-1:0] k_limit,
    input  logic [Width-1:0] n_limit,
    input  logic [Width-1:0] m_limit,
    output logic [Width-1:0] k_cnt,
    output logic [Width-1:0] n_cnt,
    output logic [Width-1:0] m_cnt,
    output logic             k_wrap,
    output logic             last
);

    logic n_wrap;
    logic m_wrap;

    // A level only wraps when every inner level wraps in the same step.
    assign k_wrap = (k_cnt == k_limit - Width'(1));
    assign n_wrap = k_wrap && (n_cnt == n_limit - Width'(1));
    assign m_wrap = n_wrap && (m_cnt == m_limit - Width'(1));
    assign last   = m_wrap;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            k_cnt <= '0;
            n_cnt <= '0;
            m_cnt <= '0;
        end else if (clear) begin
            k_cnt <= '0;
            n_cnt <= '0;
            m_cnt <= '0;
        end else if (enable) begin
            if (k_wrap) begin
                k_cnt <= '0;
                if (n_wrap) begin
                    n_cnt <= '0;
                    m_cnt <= m_wrap ? '0 : m_cnt + Width'(1);
                end else begin
                    n_cnt <= n_cnt + Width'(1);
                end
            end else begin
                k_cnt <= k_cnt + Width'(1);
            end
        end
    end

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Output-stationary GeMM tile scheduler for a RowPar x ColPar MAC array.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : host start/sizes in, busy/done out; read index strobes,
//                   array data-valid/first strobes and C-write strobes out
// Walks k innermost, then column tiles, then row tiles. Read indices are
// issued combinationally from the counters; in_valid/first follow one cycle
// later (SRAM read), and c_we one further cycle later (MAC register).
module gemm_tile_scheduler
    import gemm_tile_scheduler_pkg::*;
#(
    parameter int SizeAddrWidth = 8,
    parameter int RowPar        = 4,
    parameter int ColPar        = 16
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    gemm_tile_scheduler_if.slave bus
);

    sched_state_e             state, state_next;
    logic [1:0]               drain_cnt;
    logic [SizeAddrWidth-1:0] m_size_q, k_size_q, n_size_q;
    logic [SizeAddrWidth-1:0] m_tiles_q, n_tiles_q;
    logic                     start_accept, size_zero;
    logic                     issue, busy, done;
    logic [SizeAddrWidth-1:0] k_cnt, n_cnt, m_cnt;
    logic                     k_wrap, last;
    logic [SizeAddrWidth-1:0] row_base, col_base;
    logic [RowPar-1:0]        row_valid;
    logic [ColPar-1:0]        col_valid;

    logic                     in_valid_q, first_q, tile_end_q;
    logic [SizeAddrWidth-1:0] s1_row_base, s1_col_base;
    logic [RowPar-1:0]        s1_row_valid;
    logic [ColPar-1:0]        s1_col_valid;
    logic                     c_we_q;
    logic [SizeAddrWidth-1:0] c_row_base_q, c_col_base_q;
    logic [RowPar-1:0]        c_row_valid_q;
    logic [ColPar-1:0]        c_col_valid_q;

    assign start_accept = (state == IDLE) && bus.start;
    assign size_zero    = (bus.m_size == '0) || (bus.k_size == '0) || (bus.n_size == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
        end
    end

    always_comb begin
        state_next = state;
        issue      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = size_zero ? DONE : RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                busy  = 1'b1;
                if (last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Sizes and tile counts are frozen at start so host register writes
    // during a run cannot disturb the loop bounds.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_size_q  <= '0;
            k_size_q  <= '0;
            n_size_q  <= '0;
            m_tiles_q <= '0;
            n_tiles_q <= '0;
        end else if (start_accept) begin
            m_size_q  <= bus.m_size;
            k_size_q  <= bus.k_size;
            n_size_q  <= bus.n_size;
            m_tiles_q <= SizeAddrWidth'(ceil_div(32'(bus.m_size), 32'(RowPar)));
            n_tiles_q <= SizeAddrWidth'(ceil_div(32'(bus.n_size), 32'(ColPar)));
        end
    end

    gemm_nested_counter #(.Width(SizeAddrWidth)) u_counter (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear   (start_accept),
        .enable  (issue),
        .k_limit (k_size_q),
        .n_limit (n_tiles_q),
        .m_limit (m_tiles_q),
        .k_cnt   (k_cnt),
        .n_cnt   (n_cnt),
        .m_cnt   (m_cnt),
        .k_wrap  (k_wrap),
        .last    (last)
    );

    assign row_base = m_cnt * SizeAddrWidth'(RowPar);
    assign col_base = n_cnt * SizeAddrWidth'(ColPar);

    // Lane compare is one bit wider than the base so an edge tile near the
    // top of the address range cannot wrap back into range.
    always_comb begin
        row_valid = '0;
        col_valid = '0;
        for (int i = 0; i < RowPar; i++) begin
            row_valid[i] = issue &&
                (({1'b0, row_base} + (SizeAddrWidth+1)'(i)) < {1'b0, m_size_q});
        end
        for (int j = 0; j < ColPar; j++) begin
            col_valid[j] = issue &&
                (({1'b0, col_base} + (SizeAddrWidth+1)'(j)) < {1'b0, n_size_q});
        end
    end

    // Stage 1 tracks the SRAM read; stage 2 tracks the MAC register, so the
    // C write fires once the final k beat of a tile has been accumulated.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_valid_q    <= 1'b0;
            first_q       <= 1'b0;
            tile_end_q    <= 1'b0;
            s1_row_base   <= '0;
            s1_col_base   <= '0;
            s1_row_valid  <= '0;
            s1_col_valid  <= '0;
            c_we_q        <= 1'b0;
            c_row_base_q  <= '0;
            c_col_base_q  <= '0;
            c_row_valid_q <= '0;
            c_col_valid_q <= '0;
        end else begin
            in_valid_q    <= issue;
            first_q       <= issue && (k_cnt == '0);
            tile_end_q    <= issue && k_wrap;
            s1_row_base   <= row_base;
            s1_col_base   <= col_base;
            s1_row_valid  <= row_valid;
            s1_col_valid  <= col_valid;
            c_we_q        <= in_valid_q && tile_end_q;
            c_row_base_q  <= s1_row_base;
            c_col_base_q  <= s1_col_base;
            c_row_valid_q <= (in_valid_q && tile_end_q) ? s1_row_valid : '0;
            c_col_valid_q <= (in_valid_q && tile_end_q) ? s1_col_valid : '0;
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.issue       = issue;
    assign bus.k           = k_cnt;
    assign bus.row_base    = row_base;
    assign bus.col_base    = col_base;
    assign bus.row_valid   = row_valid;
    assign bus.col_valid   = col_valid;
    assign bus.in_valid    = in_valid_q;
    assign bus.first       = first_q;
    assign bus.c_we        = c_we_q;
    assign bus.c_row_base  = c_row_base_q;
    assign bus.c_col_base  = c_col_base_q;
    assign bus.c_row_valid = c_row_valid_q;
    assign bus.c_col_valid = c_col_valid_q;

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Self-checking bench for gemm_tile_scheduler. Each accepted start pushes one
// expected record per cycle (cycle 0 = start cycle) built from the documented
// timing; a negedge monitor pops and compares them, and checks idle outputs
// whenever no run is outstanding.
module tb_gemm_tile_scheduler;

    localparam int W = 8;
    localparam int R = 4;
    localparam int C = 16;

    logic clk;
    logic rst_ni;

    gemm_tile_scheduler_if #(.SizeAddrWidth(W), .RowPar(R), .ColPar(C)) bus ();

    gemm_tile_scheduler #(.SizeAddrWidth(W), .RowPar(R), .ColPar(C)) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        int         cyc;
        logic       busy;
        logic       done;
        logic       issue;
        logic       in_valid;
        logic       first;
        logic       c_we;
        logic [W-1:0] k;
        logic [W-1:0] row_base;
        logic [W-1:0] col_base;
        logic [W-1:0] c_row_base;
        logic [W-1:0] c_col_base;
        logic [R-1:0] row_valid;
        logic [R-1:0] c_row_valid;
        logic [C-1:0] col_valid;
        logic [C-1:0] c_col_valid;
    } exp_t;

    exp_t expQ[$];
    exp_t mon;
    int   testCount = 0;
    int   failCount = 0;
    bit   monEnable = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        testCount++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t blankRecord(input int cyc);
        exp_t r;
        r.cyc = cyc;
        r.busy = 1'b0; r.done = 1'b0; r.issue = 1'b0;
        r.in_valid = 1'b0; r.first = 1'b0; r.c_we = 1'b0;
        r.k = '0; r.row_base = '0; r.col_base = '0;
        r.c_row_base = '0; r.c_col_base = '0;
        r.row_valid = '0; r.c_row_valid = '0;
        r.col_valid = '0; r.c_col_valid = '0;
        return r;
    endfunction

    // Expected per-cycle trace for a run of m x kk x n started at cycle 0.
    task automatic pushRun(input int m, input int kk, input int n);
        exp_t r;
        int mt, nt, tt, idx, tile, rb, cb;
        expQ.push_back(blankRecord(0));
        if (m == 0 || kk == 0 || n == 0) begin
            r = blankRecord(1);
            r.busy = 1'b1;
            r.done = 1'b1;
            expQ.push_back(r);
            return;
        end
        mt = (m + R - 1) / R;
        nt = (n + C - 1) / C;
        tt = mt * nt * kk;
        for (int c = 1; c <= tt + 3; c++) begin
            r = blankRecord(c);
            r.busy = 1'b1;
            r.done = (c == tt + 3);
            if (c <= tt) begin
                idx = c - 1;
                tile = idx / kk;
                rb = (tile / nt) * R;
                cb = (tile % nt) * C;
                r.issue = 1'b1;
                r.k = W'(idx % kk);
                r.row_base = W'(rb);
                r.col_base = W'(cb);
                for (int i = 0; i < R; i++) r.row_valid[i] = (rb + i < m);
                for (int j = 0; j < C; j++) r.col_valid[j] = (cb + j < n);
            end
            if (c >= 2 && c <= tt + 1) begin
                r.in_valid = 1'b1;
                r.first = ((c - 2) % kk == 0);
            end
            if (c >= 2 && (c - 2) % kk == 0 && (c - 2) / kk >= 1 && (c - 2) / kk <= mt * nt) begin
                tile = (c - 2) / kk - 1;
                rb = (tile / nt) * R;
                cb = (tile % nt) * C;
                r.c_we = 1'b1;
                r.c_row_base = W'(rb);
                r.c_col_base = W'(cb);
                for (int i = 0; i < R; i++) r.c_row_valid[i] = (rb + i < m);
                for (int j = 0; j < C; j++) r.c_col_valid[j] = (cb + j < n);
            end
            expQ.push_back(r);
        end
    endtask

    always @(negedge clk) begin
        if (monEnable) begin
            if (expQ.size() != 0) begin
                mon = expQ.pop_front();
                checkOutput($sformatf("c%0d busy", mon.cyc), 32'(bus.busy), 32'(mon.busy));
                checkOutput($sformatf("c%0d done", mon.cyc), 32'(bus.done), 32'(mon.done));
                checkOutput($sformatf("c%0d issue", mon.cyc), 32'(bus.issue), 32'(mon.issue));
                checkOutput($sformatf("c%0d in_valid", mon.cyc), 32'(bus.in_valid), 32'(mon.in_valid));
                checkOutput($sformatf("c%0d first", mon.cyc), 32'(bus.first), 32'(mon.first));
                checkOutput($sformatf("c%0d c_we", mon.cyc), 32'(bus.c_we), 32'(mon.c_we));
                if (mon.issue) begin
                    checkOutput($sformatf("c%0d k", mon.cyc), 32'(bus.k), 32'(mon.k));
                    checkOutput($sformatf("c%0d row_base", mon.cyc), 32'(bus.row_base), 32'(mon.row_base));
                    checkOutput($sformatf("c%0d col_base", mon.cyc), 32'(bus.col_base), 32'(mon.col_base));
                    checkOutput($sformatf("c%0d row_valid", mon.cyc), 32'(bus.row_valid), 32'(mon.row_valid));
                    checkOutput($sformatf("c%0d col_valid", mon.cyc), 32'(bus.col_valid), 32'(mon.col_valid));
                end
                if (mon.c_we) begin
                    checkOutput($sformatf("c%0d c_row_base", mon.cyc), 32'(bus.c_row_base), 32'(mon.c_row_base));
                    checkOutput($sformatf("c%0d c_col_base", mon.cyc), 32'(bus.c_col_base), 32'(mon.c_col_base));
                    checkOutput($sformatf("c%0d c_row_valid", mon.cyc), 32'(bus.c_row_valid), 32'(mon.c_row_valid));
                    checkOutput($sformatf("c%0d c_col_valid", mon.cyc), 32'(bus.c_col_valid), 32'(mon.c_col_valid));
                end
            end else begin
                checkOutput("idle busy", 32'(bus.busy), 32'd0);
                checkOutput("idle done", 32'(bus.done), 32'd0);
                checkOutput("idle issue", 32'(bus.issue), 32'd0);
                checkOutput("idle in_valid", 32'(bus.in_valid), 32'd0);
                checkOutput("idle c_we", 32'(bus.c_we), 32'd0);
            end
        end
    end

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, " busy"}, 32'(bus.busy), 32'd0);
        checkOutput({pfx, " done"}, 32'(bus.done), 32'd0);
        checkOutput({pfx, " issue"}, 32'(bus.issue), 32'd0);
        checkOutput({pfx, " k"}, 32'(bus.k), 32'd0);
        checkOutput({pfx, " row_base"}, 32'(bus.row_base), 32'd0);
        checkOutput({pfx, " col_base"}, 32'(bus.col_base), 32'd0);
        checkOutput({pfx, " row_valid"}, 32'(bus.row_valid), 32'd0);
        checkOutput({pfx, " col_valid"}, 32'(bus.col_valid), 32'd0);
        checkOutput({pfx, " in_valid"}, 32'(bus.in_valid), 32'd0);
        checkOutput({pfx, " first"}, 32'(bus.first), 32'd0);
        checkOutput({pfx, " c_we"}, 32'(bus.c_we), 32'd0);
        checkOutput({pfx, " c_row_base"}, 32'(bus.c_row_base), 32'd0);
        checkOutput({pfx, " c_col_base"}, 32'(bus.c_col_base), 32'd0);
        checkOutput({pfx, " c_row_valid"}, 32'(bus.c_row_valid), 32'd0);
        checkOutput({pfx, " c_col_valid"}, 32'(bus.c_col_valid), 32'd0);
    endtask

    task automatic waitDrain();
        int cnt;
        cnt = 0;
        while (expQ.size() != 0 && cnt < 500) begin
            @(posedge clk); #1;
            cnt++;
        end
        checkOutput("drain", 32'(expQ.size()), 32'd0);
    endtask

    // Waits for the previous run to finish, idles for gap cycles, then
    // holds start for exactly one edge. Returns #1 after that edge (cycle 1).
    task automatic applyStimulus(input int m, input int kk, input int n, input int gap);
        waitDrain();
        repeat (gap) begin
            @(posedge clk); #1;
        end
        bus.m_size = W'(m);
        bus.k_size = W'(kk);
        bus.n_size = W'(n);
        bus.start  = 1'b1;
        pushRun(m, kk, n);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    initial begin
        rst_ni     = 1'b1;
        bus.start  = 1'b0;
        bus.m_size = '0;
        bus.k_size = '0;
        bus.n_size = '0;
        #1 rst_ni = 1'b0;
        #1 checkAllZero("reset");
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        monEnable = 1'b1;

        applyStimulus(4, 3, 16, 2);
        applyStimulus(5, 2, 17, 2);
        applyStimulus(8, 1, 32, 2);
        applyStimulus(4, 0, 16, 2);
        applyStimulus(0, 3, 16, 2);
        applyStimulus(5, 2, 0, 1);

        // Starts at cycles 2 and 5 plus size changes mid-run must be ignored;
        // the next run is launched the cycle after done.
        applyStimulus(5, 2, 17, 2);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.m_size = 8'd3; bus.k_size = 8'd7; bus.n_size = 8'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        applyStimulus(4, 3, 16, 0);

        // Reset in cycle 3 of a run: outputs clear at once and no done follows.
        applyStimulus(5, 2, 17, 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_ni = 1'b0;
        expQ.delete();
        #1 checkAllZero("midrst");
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;
        applyStimulus(5, 2, 17, 3);
        applyStimulus(3, 5, 20, 1);

        for (int r = 0; r < 4; r++) begin
            applyStimulus(int'($urandom_range(1, 12)), int'($urandom_range(1, 4)),
                          int'($urandom_range(1, 40)), 1);
        end

        waitDrain();
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
